// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage ahead of the 64-bit ALU: RV64I ALU-op decode, operand select, valid/ready register.
// Optional operand forwarding from EX/MEM and MEM/WB is enabled by defining ID_EX_FORWARD_EN.
module id_ex_alu_issue #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [XLEN-1:0]   imm,
  input  logic              flush,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_val,
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] rd_out,
  output logic              illegal
);

  localparam int unsigned OPW = 4;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [OPW-1:0] ALU_ADD  = OPW'(0);
  localparam logic [OPW-1:0] ALU_SUB  = OPW'(1);
  localparam logic [OPW-1:0] ALU_AND  = OPW'(2);
  localparam logic [OPW-1:0] ALU_OR   = OPW'(3);
  localparam logic [OPW-1:0] ALU_XOR  = OPW'(4);
  localparam logic [OPW-1:0] ALU_SLL  = OPW'(5);
  localparam logic [OPW-1:0] ALU_SRL  = OPW'(6);
  localparam logic [OPW-1:0] ALU_SRA  = OPW'(7);
  localparam logic [OPW-1:0] ALU_SLT  = OPW'(8);
  localparam logic [OPW-1:0] ALU_SLTU = OPW'(9);

  logic              r_valid;
  logic [XLEN-1:0]   r_alu_a;
  logic [XLEN-1:0]   r_alu_b;
  logic [OPW-1:0]    r_alu_op;
  logic [REG_AW-1:0] r_rd;
  logic              r_illegal;

  logic              w_in_ready;
  logic              w_capture;
  logic [XLEN-1:0]   w_rs1;
  logic [XLEN-1:0]   w_rs2;
  logic              w_f7_zero;
  logic              w_f7_alt;
  logic              w_f6_zero;
  logic              w_f6_alt;
  logic [OPW-1:0]    w_op;
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic [REG_AW-1:0] w_rd;
  logic              w_ill;

  assign w_in_ready = !r_valid || out_ready;
  assign w_capture  = in_valid && w_in_ready && !flush;

  // Source operand selection; EX/MEM result is younger so it wins over MEM/WB.
`ifdef ID_EX_FORWARD_EN
  always_comb begin
    w_rs1 = rs1_val;
    if (rs1_addr != '0 && memwb_we && memwb_rd == rs1_addr) w_rs1 = memwb_val;
    if (rs1_addr != '0 && exmem_we && exmem_rd == rs1_addr) w_rs1 = exmem_val;
  end

  always_comb begin
    w_rs2 = rs2_val;
    if (rs2_addr != '0 && memwb_we && memwb_rd == rs2_addr) w_rs2 = memwb_val;
    if (rs2_addr != '0 && exmem_we && exmem_rd == rs2_addr) w_rs2 = exmem_val;
  end
`else
  logic w_unused_fwd;

  assign w_rs1        = rs1_val;
  assign w_rs2        = rs2_val;
  assign w_unused_fwd = ^{rs1_addr, rs2_addr, exmem_we, exmem_rd, exmem_val,
                          memwb_we, memwb_rd, memwb_val};
`endif

  // RV64 shift-immediates carry a 6-bit shamt, so only funct7[6:1] is checked.
  assign w_f7_zero = (funct7 == 7'b0000000);
  assign w_f7_alt  = (funct7 == 7'b0100000);
  assign w_f6_zero = (funct7[6:1] == 6'b000000);
  assign w_f6_alt  = (funct7[6:1] == 6'b010000);

  always_comb begin
    w_op  = ALU_ADD;
    w_a   = '0;
    w_b   = '0;
    w_ill = 1'b0;
    case (opcode)
      OPC_R: begin
        w_a = w_rs1;
        w_b = w_rs2;
        case (funct3)
          3'b000: begin
            if (w_f7_zero)     w_op = ALU_ADD;
            else if (w_f7_alt) w_op = ALU_SUB;
            else               w_ill = 1'b1;
          end
          3'b001: begin w_op = ALU_SLL;  w_ill = !w_f7_zero; end
          3'b010: begin w_op = ALU_SLT;  w_ill = !w_f7_zero; end
          3'b011: begin w_op = ALU_SLTU; w_ill = !w_f7_zero; end
          3'b100: begin w_op = ALU_XOR;  w_ill = !w_f7_zero; end
          3'b101: begin
            if (w_f7_zero)     w_op = ALU_SRL;
            else if (w_f7_alt) w_op = ALU_SRA;
            else               w_ill = 1'b1;
          end
          3'b110: begin w_op = ALU_OR;   w_ill = !w_f7_zero; end
          default: begin w_op = ALU_AND; w_ill = !w_f7_zero; end
        endcase
      end
      OPC_I: begin
        w_a = w_rs1;
        w_b = imm;
        case (funct3)
          3'b000: w_op = ALU_ADD;
          3'b001: begin w_op = ALU_SLL; w_ill = !w_f6_zero; end
          3'b010: w_op = ALU_SLT;
          3'b011: w_op = ALU_SLTU;
          3'b100: w_op = ALU_XOR;
          3'b101: begin
            if (w_f6_zero)     w_op = ALU_SRL;
            else if (w_f6_alt) w_op = ALU_SRA;
            else               w_ill = 1'b1;
          end
          3'b110: w_op = ALU_OR;
          default: w_op = ALU_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        w_a = w_rs1;
        w_b = imm;
      end
      OPC_LUI: begin
        w_b = imm;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal entries travel downstream as a zeroed bubble with the trap flag set.
    if (w_ill) begin
      w_op = ALU_ADD;
      w_a  = '0;
      w_b  = '0;
    end
  end

  assign w_rd = w_ill ? '0 : rd_addr;

  // Output register: flush beats capture; data holds whenever nothing is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_alu_a   <= w_a;
      r_alu_b   <= w_b;
      r_alu_op  <= w_op;
      r_rd      <= w_rd;
      r_illegal <= w_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rd_out    = r_rd;
  assign illegal   = r_illegal;

endmodule
